// File: rtl/mips_timer.sv
// mips_timer -- memory-mapped timer peripheral on the MIPS data bus.
//
// Counts prescaled ticks in COUNT, sets STATUS.MATCH when a tick sees
// COUNT == COMPARE, and raises a level interrupt when MATCH and CTRL.IRQEN
// are both set.
//
// Register window (32 bytes at BASE_ADDR, offset = memaddr[4:2]):
//   0 CTRL     bit0 EN, bit1 AUTORELOAD, bit2 IRQEN
//   1 COUNT    32-bit R/W
//   2 COMPARE  32-bit R/W (reset value FFFF_FFFF)
//   3 STATUS   bit0 MATCH, write-1-to-clear
//   4 PRESCALE [PRESCALE_W-1:0] R/W (only with MIPS_TIMER_PRESCALE_EN)
//   5..7       read 0, writes ignored
//
// Build option: define MIPS_TIMER_PRESCALE_EN to include the prescaler.
// Without it every enabled cycle is a tick and offset 4 reads 0.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   memwrite     store strobe from the CPU MEM stage
//   memaddr      byte address (bits [1:0] ignored)
//   memwritedata store data
//   memreaddata  combinational load data (0 when not selected)
//   sel          address falls inside the register window
//   irq          level interrupt request = MATCH & IRQEN
module mips_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0100,
   parameter int          PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic [31:0] memreaddata,
   output logic        sel,
   output logic        irq
);

   logic [2:0]  ctrl_reg;
   logic [31:0] count_reg;
   logic [31:0] compare_reg;
   logic        match_reg;

   logic [7:0]  wr_sel;
   logic        tick;
   logic        count_hit;
   logic [31:0] prescale_rd;
   logic        unused_bits;

   assign sel = (memaddr[31:5] == BASE_ADDR[31:5]);

   // One write strobe per register offset.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_wr_dec
         assign wr_sel[gi] = memwrite & sel & (memaddr[4:2] == 3'(gi));
      end
   endgenerate

`ifdef MIPS_TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] pcnt_reg;
   logic [PRESCALE_W-1:0] prescale_reg;

   assign tick = ctrl_reg[0] & (pcnt_reg == prescale_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_reg     <= '0;
         prescale_reg <= '0;
      end else begin
         if (wr_sel[4])
            prescale_reg <= memwritedata[PRESCALE_W-1:0];
         // Reprogramming CTRL or PRESCALE restarts the tick period cleanly.
         if (wr_sel[0] | wr_sel[4])
            pcnt_reg <= '0;
         else if (ctrl_reg[0])
            pcnt_reg <= tick ? '0 : pcnt_reg + PRESCALE_W'(1);
      end
   end

   always_comb begin
      prescale_rd                 = '0;
      prescale_rd[PRESCALE_W-1:0] = prescale_reg;
   end

   assign unused_bits = ^{memaddr[1:0], wr_sel[7:5]};
`else
   assign tick        = ctrl_reg[0];
   assign prescale_rd = '0;
   assign unused_bits = ^{memaddr[1:0], wr_sel[7:4], PRESCALE_W[0]};
`endif

   assign count_hit = (count_reg == compare_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_reg    <= '0;
         count_reg   <= '0;
         compare_reg <= 32'hFFFF_FFFF;
         match_reg   <= 1'b0;
      end else begin
         if (wr_sel[0])
            ctrl_reg <= memwritedata[2:0];
         if (wr_sel[2])
            compare_reg <= memwritedata;

         // CPU store beats the tick; the match below still uses the old COUNT.
         if (wr_sel[1])
            count_reg <= memwritedata;
         else if (tick)
            count_reg <= (count_hit & ctrl_reg[1]) ? 32'd0 : count_reg + 32'd1;

         // A new match wins over a simultaneous write-1-to-clear.
         if (tick & count_hit)
            match_reg <= 1'b1;
         else if (wr_sel[3] & memwritedata[0])
            match_reg <= 1'b0;
      end
   end

   assign irq = match_reg & ctrl_reg[2];

   always_comb begin
      memreaddata = 32'h0;
      if (sel) begin
         case (memaddr[4:2])
            3'd0:    memreaddata = {29'h0, ctrl_reg};
            3'd1:    memreaddata = count_reg;
            3'd2:    memreaddata = compare_reg;
            3'd3:    memreaddata = {31'h0, match_reg};
            3'd4:    memreaddata = prescale_rd;
            default: memreaddata = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_timer.sv
// Randomised self-checking bench for mips_timer with directed scenarios.
// A behavioural model tracks the register file from the register-map rules
// and every cycle's load data, sel and irq are compared against it.
module tb_mips_timer;

   localparam logic [31:0] BASE = 32'hFFFF_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] memaddr;
   logic [31:0] memwritedata;
   logic [31:0] memreaddata;
   logic        sel;
   logic        irq;

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model state
   bit          m_en, m_ar, m_ie, m_match;
   logic [31:0] m_count, m_compare;
   int unsigned m_pcnt, m_prescale;

   mips_timer #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .memwrite     (memwrite),
      .memaddr      (memaddr),
      .memwritedata (memwritedata),
      .memreaddata  (memreaddata),
      .sel          (sel),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic bit m_in_window(input logic [31:0] a);
      return (a & 32'hFFFF_FFE0) == BASE;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int unsigned off;
      if (!m_in_window(a)) return 32'h0;
      off = (a >> 2) % 8;
      case (off)
         0: return {29'h0, m_ie, m_ar, m_en};
         1: return m_count;
         2: return m_compare;
         3: return {31'h0, m_match};
`ifdef MIPS_TIMER_PRESCALE_EN
         4: return m_prescale;
`endif
         default: return 32'h0;
      endcase
   endfunction

   // Apply one rising edge to the model.
   task automatic m_step(input bit rst, input bit w, input logic [31:0] a, input logic [31:0] d);
      int unsigned off;
      bit hit, is_tick, matched;
      if (rst) begin
         {m_en, m_ar, m_ie, m_match} = '0;
         m_count    = 0;
         m_compare  = 32'hFFFF_FFFF;
         m_pcnt     = 0;
         m_prescale = 0;
         return;
      end
      hit = w && m_in_window(a);
      off = (a >> 2) % 8;
`ifdef MIPS_TIMER_PRESCALE_EN
      is_tick = m_en && (m_pcnt == m_prescale);
`else
      is_tick = m_en;
`endif
      matched = is_tick && (m_count == m_compare);

      // prescale counter: period PRESCALE+1, restarted by CTRL/PRESCALE writes
      if (hit && (off == 0 || off == 4)) m_pcnt = 0;
      else if (m_en)                      m_pcnt = is_tick ? 0 : m_pcnt + 1;

      if (hit && off == 1)  m_count = d;
      else if (matched && m_ar) m_count = 0;
      else if (is_tick)     m_count = m_count + 32'd1;

      if (matched)                          m_match = 1;
      else if (hit && off == 3 && (d % 2) == 1) m_match = 0;

      if (hit && off == 0) begin
         m_en = (d % 2) == 1;
         m_ar = ((d / 2) % 2) == 1;
         m_ie = ((d / 4) % 2) == 1;
      end
      if (hit && off == 2) m_compare = d;
      if (hit && off == 4) m_prescale = d % 256;
   endtask

   // One bus cycle: drive, check combinational outputs, advance model at edge.
   task automatic cyc(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit rst, output logic [31:0] rdata, output logic irq_s);
      @(negedge clk);
      reset        = rst;
      memwrite     = w;
      memaddr      = a;
      memwritedata = d;
      #1;
      rdata = memreaddata;
      irq_s = irq;
      $display("t=%0t rst=%0d wr=%0d addr=%08h wdata=%08h rdata=%08h irq=%0d",
               $time, rst, w, a, d, memreaddata, irq);
      check("rdata", memreaddata, m_read(a));
      check("sel", {31'h0, sel}, {31'h0, m_in_window(a)});
      check("irq", {31'h0, irq}, {31'h0, m_match & m_ie});
      @(posedge clk);
      m_step(rst, w, a, d);
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      logic [31:0] r;
      logic i;
      cyc(1'b1, BASE + 32'(off * 4), d, 1'b0, r, i);
   endtask

   task automatic rdx(input string tag, input int off, input logic [31:0] exp);
      logic [31:0] r;
      logic i;
      cyc(1'b0, BASE + 32'(off * 4), 32'h0, 1'b0, r, i);
      check(tag, r, exp);
   endtask

   task automatic do_reset();
      logic [31:0] r;
      logic i;
      cyc(1'b0, BASE + 32'd8, 32'h0, 1'b1, r, i);
      cyc(1'b0, BASE + 32'd8, 32'h0, 1'b1, r, i);
      check("rst_held_compare", r, 32'hFFFF_FFFF);
      check("rst_held_irq", {31'h0, i}, 32'h0);
   endtask

   initial begin
      logic [31:0] r;
      logic        i;
      logic [31:0] rst_exp [8];
      int          lat;
      int          exp_lat;

      reset = 1'b1; memwrite = 1'b0; memaddr = 32'h0; memwritedata = 32'h0;
      repeat (2) @(posedge clk);
      m_step(1'b1, 1'b0, 32'h0, 32'h0);
      do_reset();

      // Reset values of the whole window, and an out-of-window address
      rst_exp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int k = 0; k < 8; k++) rdx("rst_reg", k, rst_exp[k]);
      @(negedge clk);
      reset = 1'b0; memwrite = 1'b0; memaddr = 32'h0000_0100;
      #1;
      check("sel_outside", {31'h0, sel}, 32'h0);
      check("rd_outside", memreaddata, 32'h0);
      @(posedge clk);
      m_step(1'b0, 1'b0, 32'h0000_0100, 32'h0);

      // Match latency: six ticks of (PRESCALE+1) cycles
      wr(4, 3); wr(2, 5); wr(0, 7);
`ifdef MIPS_TIMER_PRESCALE_EN
      exp_lat = 24;
`else
      exp_lat = 6;
`endif
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         cyc(1'b0, BASE + 32'd12, 32'h0, 1'b0, r, i);
         #1;
         if (irq === 1'b1) begin
            lat = k;
            break;
         end
      end
      check("match_latency", 32'(lat), 32'(exp_lat));
      rdx("autoreload_count", 1, 32'h0);
      rdx("match_set", 3, 32'h1);

      // 32-bit wrap without autoreload never matches
      do_reset();
      wr(4, 0); wr(2, 10); wr(1, 32'hFFFF_FFFE); wr(0, 1);
      rdx("wrap_c0", 1, 32'hFFFF_FFFE);
      rdx("wrap_c1", 1, 32'hFFFF_FFFF);
      rdx("wrap_c2", 1, 32'h0);
      rdx("wrap_c3", 1, 32'h1);
      rdx("wrap_nomatch", 3, 32'h0);

      // W1C against a simultaneous match, then a plain clear
      do_reset();
      wr(4, 0); wr(2, 0); wr(0, 7);
      cyc(1'b0, BASE, 32'h0, 1'b0, r, i);
      wr(3, 1);
      cyc(1'b0, BASE + 32'd12, 32'h0, 1'b0, r, i);
      check("set_beats_clr", r, 32'h1);
      check("set_beats_clr_irq", {31'h0, i}, 32'h1);
      wr(0, 4);
      wr(3, 1);
      cyc(1'b0, BASE + 32'd12, 32'h0, 1'b0, r, i);
      check("w1c_status", r, 32'h0);
      check("w1c_irq", {31'h0, i}, 32'h0);

      // COUNT write on a matching tick, and an out-of-window store
      do_reset();
      wr(4, 0); wr(2, 7); wr(1, 7); wr(0, 1);
      wr(1, 100);
      rdx("wr_prio_count", 1, 32'd100);
      rdx("wr_prio_match", 3, 32'h1);
      wr(0, 0);
      wr(1, 100);
      cyc(1'b1, 32'h0000_0104, 32'd55, 1'b0, r, i);
      rdx("foreign_count", 1, 32'd100);
      rdx("foreign_compare", 2, 32'd7);

      // PRESCALE register presence and count rate with PRESCALE=9
      do_reset();
      wr(4, 9);
`ifdef MIPS_TIMER_PRESCALE_EN
      rdx("prescale_rd", 4, 32'd9);
`else
      rdx("prescale_rd", 4, 32'd0);
`endif
      wr(0, 1);
      for (int k = 0; k < 3; k++) begin
`ifdef MIPS_TIMER_PRESCALE_EN
         rdx("rate_count", 1, 32'd0);
`else
         rdx("rate_count", 1, 32'(k));
`endif
      end

      // Randomised traffic against the model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [31:0] a, d;
         bit          w, rst;
         int unsigned off;
         rst = ($urandom_range(0, 99) == 0);
         w   = ($urandom_range(0, 2) == 0);
         off = $urandom_range(0, 7);
         case ($urandom_range(0, 9))
            0:       a = 32'h0000_0104;
            1:       a = $urandom;
            default: a = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
         endcase
         case (off)
            0:       d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7))
                                                     : (32'($urandom_range(0, 7)) | 32'h1);
            1, 2:    d = 32'($urandom_range(0, 12));
            4:       d = 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_FF00);
            default: d = $urandom;
         endcase
         cyc(w, a, d, rst, r, i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_timer.md
MIPS_TIMER -- requirements
Module: mips_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_0100: base of the 32-byte register window, aligned to 32 bytes.
REQ-002 Parameter PRESCALE_W, default 8: prescaler width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memwrite  input  1  store strobe from the CPU MEM stage.
REQ-006 memaddr  input  32  byte address from the CPU MEM stage; bits [1:0] ignored.
REQ-007 memwritedata  input  32  store data.
REQ-008 memreaddata  output  32  load data, combinational from memaddr and register state.
REQ-009 sel  output  1  high when memaddr[31:5] == BASE_ADDR[31:5]; used by the system read-mux.
REQ-010 irq  output  1  interrupt request, level-sensitive.

Function
REQ-011 Register map at offset memaddr[4:2]:
- 0 = CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
- 1 = COUNT (32-bit, R/W).
- 2 = COMPARE (32-bit, R/W).
- 3 = STATUS: bit0 MATCH, write-1-to-clear.
- 4 = PRESCALE ([PRESCALE_W-1:0], R/W).
- 5..7 read 0; writes to them are ignored.
REQ-012 A write takes effect at the rising edge where memwrite=1 and sel=1; writes with sel=0 change no state.
REQ-013 memreaddata equals the addressed register when sel=1, and 32'h0 when sel=0; there is no read side effect.
REQ-014 Internal prescale counter pcnt (PRESCALE_W bits) increments on every cycle with EN=1. When pcnt == PRESCALE, tick=1 and pcnt returns to 0, so the tick period is PRESCALE+1 cycles.
REQ-015 When EN=0, pcnt holds, tick=0, and COUNT holds.
REQ-016 On tick, if COUNT == COMPARE:
- MATCH is set to 1.
- COUNT becomes 0 if AUTORELOAD=1, otherwise COUNT+1.
REQ-017 On tick with COUNT != COMPARE, COUNT becomes COUNT+1, wrapping 32'hFFFF_FFFF to 0; the wrap does not set MATCH.
REQ-018 A CPU write to COUNT in the same cycle as a tick takes priority: COUNT takes memwritedata. MATCH is still evaluated against the pre-write COUNT.
REQ-019 A MATCH set and a W1C clear in the same cycle: set wins, and MATCH stays 1.
REQ-020 Any write to CTRL or PRESCALE clears pcnt to 0 at the same edge.
REQ-021 irq = MATCH & IRQEN, derived combinationally from registered bits; clearing IRQEN masks irq without clearing MATCH.
REQ-022 Latency: a write is visible on memreaddata the cycle after the write edge. MATCH rises at the edge where the matching tick occurs, and irq follows in the same cycle.

Reset
REQ-023 When reset=1 at a rising edge, all of the following are cleared to 0: CTRL, COUNT, STATUS, pcnt, and PRESCALE. COMPARE is set to 32'hFFFF_FFFF.
REQ-024 Reset overrides any simultaneous write or tick. While reset is held: irq=0, and memreaddata reflects the reset values.
REQ-025 Reset asserted mid-count abandons the count; no MATCH is produced on the edge where reset is released.

Configuration
REQ-026 Macro MIPS_TIMER_PRESCALE_EN controls the prescaler.
- Defined: the prescaler behaves per REQ-014/REQ-020.
- Undefined: pcnt and PRESCALE are not implemented, tick = EN every cycle, offset 4 reads 0, and writes to offset 4 are ignored.

Verification
REQ-027 Reset, then read offsets 0..7 -> 0, 0, FFFF_FFFF, 0, 0, 0, 0, 0; irq=0; sel=0 for memaddr=0000_0100.
REQ-028 PRESCALE=3, COMPARE=5, CTRL=7 -> MATCH=1 and irq=1 exactly 24 cycles after the CTRL write edge (6 ticks × 4 cycles); COUNT reads 0 after the match.
REQ-029 AUTORELOAD=0, COUNT=FFFF_FFFE, COMPARE=10, PRESCALE=0, EN=1 -> COUNT reads FFFF_FFFF, then 0, then 1; MATCH=0 throughout.
REQ-030 MATCH=1, then write STATUS=1 in the same cycle as a new matching tick -> MATCH stays 1. Write STATUS=1 on a non-tick cycle -> MATCH=0 and irq=0 the next cycle.
REQ-031 Write COUNT=100 on a tick cycle with COUNT=COMPARE=7 -> COUNT reads 100 and MATCH=1. A write with memaddr=0000_0104 changes no register.
REQ-032 Build without MIPS_TIMER_PRESCALE_EN, write PRESCALE=9, EN=1 -> COUNT increments every cycle and offset 4 reads 0.
